tt_um_monobit: RTL and testbench

TT_UM_MONOBIT -- requirements
Module: tt_um_monobit

---
 rtl/monobit_pkg.sv | 19 +
 rtl/monobit_if.sv | 29 ++
 rtl/monobit_core.sv | 91 +++++++++
 rtl/tt_um_monobit.sv | 44 ++++
 tb/tb_tt_um_monobit.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/monobit_pkg.sv
// Shared types and defaults for the monobit (frequency) randomness tester.
package monobit_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam int unsigned DEF_N_BITS = 128;
  localparam int unsigned DEF_THRESH = 29;

  // |2*ones - n| without signed intermediates
  function automatic int unsigned abs_excess(input int unsigned ones, input int unsigned n);
    if (2 * ones >= n) return 2 * ones - n;
    else               return n - 2 * ones;
  endfunction

endpackage

// File: rtl/monobit_if.sv
// Bit stream in, block verdict out, between pin mapping and the test core.
interface monobit_if #(
  parameter int unsigned N_BITS = 128
);
  localparam int unsigned CW = $clog2(N_BITS) + 1;

  logic          en;
  logic          start;
  logic          bit_valid;
  logic          bit_in;
  logic          busy;
  logic          done;
  logic          pass;
  logic          fail;
  logic [CW-1:0] abs_s;
  logic [CW-1:0] ones;
  logic [3:0]    blk_cnt;

  modport master (
    output en, start, bit_valid, bit_in,
    input  busy, done, pass, fail, abs_s, ones, blk_cnt
  );

  modport slave (
    input  en, start, bit_valid, bit_in,
    output busy, done, pass, fail, abs_s, ones, blk_cnt
  );

endinterface

// File: rtl/monobit_core.sv
// Monobit test core: collects N_BITS bits, counts ones and grades |2*ones - N|.
module monobit_core
  import monobit_pkg::*;
#(
  parameter int unsigned N_BITS = DEF_N_BITS,
  parameter int unsigned THRESH = DEF_THRESH
) (
  input  logic     clk,
  input  logic     rst_n,
  monobit_if.slave bus
);

  localparam int unsigned CW = $clog2(N_BITS) + 1;

  state_t        state, state_n;
  logic [CW-1:0] bit_cnt, bit_cnt_n;
  logic [CW-1:0] ones, ones_n;
  logic [CW-1:0] ones_acc;
  logic [CW-1:0] abs_q, abs_n;
  logic          done_q, done_n;
  logic          pass_q, pass_n;
  logic          fail_q, fail_n;
  logic [3:0]    blk_q, blk_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      ones    <= '0;
      abs_q   <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      blk_q   <= '0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      ones    <= ones_n;
      abs_q   <= abs_n;
      done_q  <= done_n;
      pass_q  <= pass_n;
      fail_q  <= fail_n;
      blk_q   <= blk_n;
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    ones_n    = ones;
    abs_n     = abs_q;
    done_n    = done_q;
    pass_n    = pass_q;
    fail_n    = fail_q;
    blk_n     = blk_q;
    ones_acc  = ones + CW'(bus.bit_in);

    if (bus.en) begin
      if (bus.start) begin
        state_n   = COLLECT;
        bit_cnt_n = '0;
        ones_n    = '0;
        abs_n     = '0;
        done_n    = 1'b0;
        pass_n    = 1'b0;
        fail_n    = 1'b0;
      end else if (state == COLLECT && bus.bit_valid) begin
        bit_cnt_n = bit_cnt + CW'(1);
        ones_n    = ones_acc;
        // Grade from the count including this final bit so the verdict lands with DONE
        if (bit_cnt == CW'(N_BITS - 1)) begin
          state_n = DONE;
          abs_n   = CW'(abs_excess(32'(ones_acc), N_BITS));
          done_n  = 1'b1;
          pass_n  = (abs_n <= CW'(THRESH));
          fail_n  = !pass_n;
          blk_n   = blk_q + 4'd1;
        end
      end
    end
  end

  assign bus.busy    = (state == COLLECT);
  assign bus.done    = done_q;
  assign bus.pass    = pass_q;
  assign bus.fail    = fail_q;
  assign bus.abs_s   = abs_q;
  assign bus.ones    = ones;
  assign bus.blk_cnt = blk_q;

endmodule

// File: rtl/tt_um_monobit.sv
// Tiny Tapeout wrapper: pin mapping, ena gating and result byte mux around monobit_core.
module tt_um_monobit
  import monobit_pkg::*;
#(
  parameter int unsigned N_BITS = DEF_N_BITS,
  parameter int unsigned THRESH = DEF_THRESH
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  monobit_if #(.N_BITS(N_BITS)) bus ();

  logic out_sel;
  logic unused;

  assign bus.en        = ena;
  assign bus.bit_in    = ui_in[0] & ena;
  assign bus.bit_valid = ui_in[1] & ena;
  assign bus.start     = ui_in[2] & ena;
  assign out_sel       = ui_in[3] & ena;

  monobit_core #(
    .N_BITS (N_BITS),
    .THRESH (THRESH)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign uo_out  = {bus.blk_cnt, bus.fail, bus.pass, bus.done, bus.busy};
  assign uio_out = out_sel ? 8'(bus.ones) : 8'(bus.abs_s);
  assign uio_oe  = 8'hFF;

  assign unused = &{1'b0, ui_in[7:4], uio_in};

endmodule

// File: tb/tb_tt_um_monobit.sv
// Randomized bench for tt_um_monobit against a count-the-ones reference model.
module tb_tt_um_monobit;

  localparam int NB = 128;
  localparam int TH = 29;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       out_sel;
  logic [7:0] ui_in, uo_out, uio_in, uio_out, uio_oe;

  int checks = 0;
  int errors = 0;
  int exp_blk = 0;

  monobit_if #(.N_BITS(NB)) mon ();

  assign ui_in       = {4'b0000, out_sel, mon.start, mon.bit_valid, mon.bit_in};
  assign mon.busy    = uo_out[0];
  assign mon.done    = uo_out[1];
  assign mon.pass    = uo_out[2];
  assign mon.fail    = uo_out[3];
  assign mon.blk_cnt = uo_out[7:4];
  assign mon.abs_s   = '0;
  assign mon.ones    = '0;

  tt_um_monobit #(.N_BITS(NB), .THRESH(TH)) dut (
    .ui_in(ui_in), .uo_out(uo_out), .uio_in(uio_in), .uio_out(uio_out),
    .uio_oe(uio_oe), .ena(mon.en), .clk(clk), .rst_n(rst_n)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic int model_abs(input int k);
    return (2 * k >= NB) ? 2 * k - NB : NB - 2 * k;
  endfunction

  function automatic logic [NB-1:0] make_vec(input int k);
    logic [NB-1:0] v;
    logic t;
    int j;
    v = '0;
    for (int i = 0; i < k; i++) v[i] = 1'b1;
    for (int i = NB - 1; i > 0; i--) begin
      j = $urandom_range(i, 0);
      t = v[i]; v[i] = v[j]; v[j] = t;
    end
    return v;
  endfunction

  // Start pulse (with a colliding bit_valid), then the vector with optional gaps and ena stall.
  task automatic run_block(input logic [NB-1:0] vec, input int gap_pct, input int ena_at);
    int i;
    mon.start = 1'b1; mon.bit_valid = 1'b1; mon.bit_in = 1'($urandom);
    step;
    mon.start = 1'b0;
    i = 0;
    while (i < NB) begin
      if (i == ena_at) begin
        mon.en = 1'b0;
        repeat (10) begin
          mon.start = 1'($urandom); mon.bit_valid = 1'($urandom); mon.bit_in = 1'($urandom);
          step;
        end
        mon.en = 1'b1; mon.start = 1'b0;
        ena_at = -1;
      end
      if (int'($urandom_range(99)) < gap_pct) begin
        mon.bit_valid = 1'b0; mon.bit_in = 1'($urandom);
      end else begin
        mon.bit_valid = 1'b1; mon.bit_in = vec[i];
        i++;
      end
      step;
    end
    mon.bit_valid = 1'b0;
    exp_blk = (exp_blk + 1) % 16;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; mon.en = 1'b1; mon.start = 1'b0; mon.bit_valid = 1'b0; mon.bit_in = 1'b0;
    out_sel = 1'b0; uio_in = 8'($urandom);
    #12;
    checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL reset uo_out: got %h want 00", uo_out); end
    checks++; if (uio_out !== 8'h00) begin errors++; $display("FAIL reset uio_out: got %h want 00", uio_out); end
    checks++; if (uio_oe !== 8'hFF) begin errors++; $display("FAIL reset uio_oe: got %h want FF", uio_oe); end
    rst_n = 1'b1;
    mon.bit_valid = 1'b1; mon.bit_in = 1'b1;
    repeat (3) step;
    mon.bit_valid = 1'b0;
    out_sel = 1'b1; #1;
    checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL idle_ignore uo_out: got %h want 00", uo_out); end
    checks++; if (uio_out !== 8'h00) begin errors++; $display("FAIL idle_ignore ones: got %0d want 0", uio_out); end
    out_sel = 1'b0;
    exp_blk = 0;
  endtask

  task automatic test_all_ones;
    run_block('1, 0, -1);
    checks++; if (uo_out[3:0] !== 4'b1010) begin errors++; $display("FAIL all_ones flags: got %b want 1010", uo_out[3:0]); end
    checks++; if (mon.blk_cnt !== 4'(exp_blk)) begin errors++; $display("FAIL all_ones blk: got %0d want %0d", mon.blk_cnt, exp_blk); end
    out_sel = 1'b0; #1;
    checks++; if (uio_out !== 8'd128) begin errors++; $display("FAIL all_ones abs: got %0d want 128", uio_out); end
    out_sel = 1'b1; #1;
    checks++; if (uio_out !== 8'd128) begin errors++; $display("FAIL all_ones ones: got %0d want 128", uio_out); end
    out_sel = 1'b0;
  endtask

  task automatic test_alternating;
    logic [NB-1:0] v;
    for (int i = 0; i < NB; i++) v[i] = (i % 2 == 0);
    run_block(v, 0, -1);
    checks++; if (uo_out[3:0] !== 4'b0110) begin errors++; $display("FAIL alt flags: got %b want 0110", uo_out[3:0]); end
    #1;
    checks++; if (uio_out !== 8'd0) begin errors++; $display("FAIL alt abs: got %0d want 0", uio_out); end
  endtask

  task automatic test_thresh;
    int ks[6];
    int a;
    logic ep;
    logic [7:0] held;
    ks = '{78, 79, 50, 49, int'($urandom_range(NB)), int'($urandom_range(NB))};
    foreach (ks[n]) begin
      run_block(make_vec(ks[n]), 0, -1);
      a = model_abs(ks[n]); ep = (a <= TH);
      checks++; if (uo_out[3:1] !== {~ep, ep, 1'b1}) begin errors++; $display("FAIL thresh k=%0d flags: got %b want %b", ks[n], uo_out[3:1], {~ep, ep, 1'b1}); end
      checks++; if (uio_out !== 8'(a)) begin errors++; $display("FAIL thresh k=%0d abs: got %0d want %0d", ks[n], uio_out, a); end
      checks++; if (mon.blk_cnt !== 4'(exp_blk)) begin errors++; $display("FAIL thresh k=%0d blk: got %0d want %0d", ks[n], mon.blk_cnt, exp_blk); end
      held = uo_out;
      mon.bit_valid = 1'b1;
      repeat (5) begin mon.bit_in = 1'($urandom); step; end
      mon.bit_valid = 1'b0;
      checks++; if (uo_out !== held || uio_out !== 8'(a)) begin errors++; $display("FAIL done_hold k=%0d: got %h/%0d want %h/%0d", ks[n], uo_out, uio_out, held, a); end
    end
  endtask

  task automatic test_gaps_ena;
    int k;
    for (int r = 0; r < 2; r++) begin
      k = $urandom_range(NB);
      run_block(make_vec(k), 40, (r == 1) ? int'($urandom_range(120, 5)) : -1);
      checks++; if (uio_out !== 8'(model_abs(k)) || mon.done !== 1'b1) begin errors++; $display("FAIL gaps r=%0d abs/done: got %0d/%b want %0d/1", r, uio_out, mon.done, model_abs(k)); end
      out_sel = 1'b1; #1;
      checks++; if (uio_out !== 8'(k)) begin errors++; $display("FAIL gaps r=%0d ones: got %0d want %0d", r, uio_out, k); end
      out_sel = 1'b0;
    end
  endtask

  task automatic test_restart;
    int k;
    mon.start = 1'b1; step; mon.start = 1'b0;
    checks++; if (uo_out[3:0] !== 4'b0001) begin errors++; $display("FAIL restart flags: got %b want 0001", uo_out[3:0]); end
    mon.bit_valid = 1'b1;
    repeat (60) begin mon.bit_in = 1'($urandom); step; end
    mon.bit_valid = 1'b0;
    k = $urandom_range(NB);
    run_block(make_vec(k), 10, -1);
    checks++; if (uio_out !== 8'(model_abs(k))) begin errors++; $display("FAIL restart abs: got %0d want %0d", uio_out, model_abs(k)); end
    out_sel = 1'b1; #1;
    checks++; if (uio_out !== 8'(k)) begin errors++; $display("FAIL restart ones: got %0d want %0d", uio_out, k); end
    out_sel = 1'b0;
  endtask

  task automatic test_reset_mid;
    mon.start = 1'b1; step; mon.start = 1'b0;
    mon.bit_valid = 1'b1;
    repeat (100) begin mon.bit_in = 1'($urandom); step; end
    rst_n = 1'b0; #2;
    checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL rst_mid uo_out: got %h want 00", uo_out); end
    out_sel = 1'b1; #1;
    checks++; if (uio_out !== 8'h00) begin errors++; $display("FAIL rst_mid ones: got %0d want 0", uio_out); end
    out_sel = 1'b0;
    step;
    rst_n = 1'b1;
    repeat (30) begin mon.bit_in = 1'b1; step; end
    mon.bit_valid = 1'b0;
    checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL rst_mid after: got %h want 00", uo_out); end
    exp_blk = 0;
  endtask

  task automatic test_back_to_back;
    int k;
    for (int b = 0; b < 17; b++) begin
      k = $urandom_range(NB);
      run_block(make_vec(k), 5, -1);
      out_sel = 1'b0; #1;
      checks++; if (uio_out !== 8'(model_abs(k))) begin errors++; $display("FAIL b2b blk%0d abs: got %0d want %0d", b, uio_out, model_abs(k)); end
      out_sel = 1'b1; #1;
      checks++; if (uio_out !== 8'(k)) begin errors++; $display("FAIL b2b blk%0d ones: got %0d want %0d", b, uio_out, k); end
      out_sel = 1'b0;
    end
    checks++; if (mon.blk_cnt !== 4'd1 || exp_blk != 1) begin errors++; $display("FAIL b2b wrap: got %0d want 1", mon.blk_cnt); end
  endtask

  initial begin
    test_reset;
    test_all_ones;
    test_alternating;
    test_thresh;
    test_gaps_ena;
    test_restart;
    test_reset_mid;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
